// File: rtl/mc_exec_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mc_exec_sequencer
//
// Purpose:
//   Sequencer for multi-cycle execute-stage operations. It decodes the E-stage
//   ALU control code into single-cycle, multiply, long-multiply and divide
//   classes. It holds the instruction in E for the operation's occupancy and
//   drives stall/bubble controls to the hazard logic. Long multiplies get two
//   writebacks: the lo half first (LO), then the hi half (HI).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low
//   ValidE       in   a non-bubble instruction occupies E this cycle
//   CondExE      in   condition passed (0 => treated as single-cycle)
//   ALUControlE  in   operation code of the E instruction
//   DivZeroE     in   divisor is zero (looked at only in the start cycle)
//   AbortE       in   kill the E instruction (flush logic)
//   StallF/D/E   out  hold the F/D/E pipeline registers
//   FlushM       out  insert a bubble into M
//   LoWriteE     out  E->M transfer is the lo half of a long multiply
//   HiPhaseE     out  E->M transfer is the hi half (RdHi destination)
//   BusyE        out  a multi-cycle op occupies E (includes its start cycle)
//   DoneE        out  pulse in the final E cycle of a multi-cycle op
//   DebugStateE  out  current FSM state (IDLE=0, RUN=1, LO=2, HI=3)
//   DebugCntE    out  current RUN down-counter value
//
// Qualification: ValidE marks an instruction that is really present in E. It
// is only looked at in IDLE. Once an op has started, E is frozen by our own
// stall, so ValidE/ALUControlE/CondExE hold the same instruction and are ignored.
// The hazard logic must accept every stall in the cycle it is raised; there is
// no back-pressure path into this block. AbortE wins over everything.
// -----------------------------------------------------------------------------
module mc_exec_sequencer #(
  parameter int ALUCONTROL_WIDTH = 5,
  parameter int MUL_CYCLES       = 2,
  parameter int DIV_CYCLES       = 32,
  parameter int CNT_WIDTH        = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ValidE,
  input  logic                        CondExE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic                        DivZeroE,
  input  logic                        AbortE,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        StallE,
  output logic                        FlushM,
  output logic                        LoWriteE,
  output logic                        HiPhaseE,
  output logic                        BusyE,
  output logic                        DoneE,
  output logic [1:0]                  DebugStateE,
  output logic [CNT_WIDTH-1:0]        DebugCntE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LO   = 2'd2,
    HI   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MULT   = 2'd1,
    CLS_LONG   = 2'd2,
    CLS_DIV    = 2'd3
  } op_class_t;

  // Operation codes of the multi-cycle instructions.
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MUL   = ALUCONTROL_WIDTH'(7);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MLA   = ALUCONTROL_WIDTH'(8);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MLS   = ALUCONTROL_WIDTH'(9);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UMULL = ALUCONTROL_WIDTH'(10);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UMLAL = ALUCONTROL_WIDTH'(11);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SMULL = ALUCONTROL_WIDTH'(12);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SMLAL = ALUCONTROL_WIDTH'(13);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV  = ALUCONTROL_WIDTH'(14);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV  = ALUCONTROL_WIDTH'(15);

  // A long multiply holds E for MUL_CYCLES+1 cycles in total, and the last two
  // of them are LO and HI. That leaves MUL_CYCLES-1 stalled compute cycles,
  // counting the start cycle. The start cycle always exists, so there is a
  // floor of one compute cycle.
  localparam int LONG_COMPUTE = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;

  // The counter values loaded on entry to RUN. The start cycle is one of the N
  // cycles and the counter reaches 0 in the last RUN cycle, so the load is N-2.
  localparam logic [CNT_WIDTH-1:0] MUL_LOAD  =
    CNT_WIDTH'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  =
    CNT_WIDTH'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam logic [CNT_WIDTH-1:0] LONG_LOAD =
    CNT_WIDTH'((LONG_COMPUTE > 1) ? LONG_COMPUTE - 2 : 0);

  state_t                 state;
  state_t                 stateNext;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cntNext;
  logic                   longQ;      // the running op is a long multiply
  logic                   longNext;
  op_class_t              opClass;
  logic                   startE;
  logic                   holdE;      // common stall for F, D and E

  // ---------------------------------------------------------------------------
  // Class decode
  // ---------------------------------------------------------------------------
  always_comb begin
    opClass = CLS_SINGLE;
    case (ALUControlE)
      OP_MUL, OP_MLA, OP_MLS:               opClass = CLS_MULT;
      OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL: opClass = CLS_LONG;
      OP_UDIV, OP_SDIV:                     opClass = CLS_DIV;
      default:                              opClass = CLS_SINGLE;
    endcase
  end

  // A failed condition executes as a no-op, so it never needs extra cycles.
  assign startE = ValidE & CondExE & ~AbortE & (state == IDLE)
                & (opClass != CLS_SINGLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      longQ <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      longQ <= longNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    longNext  = longQ;
    holdE     = 1'b0;
    FlushM    = 1'b0;
    LoWriteE  = 1'b0;
    HiPhaseE  = 1'b0;
    BusyE     = 1'b0;
    DoneE     = 1'b0;

    case (state)
      IDLE: begin
        if (startE) begin
          BusyE = 1'b1;
          case (opClass)
            CLS_MULT: begin
              if (MUL_CYCLES == 1) begin
                // A one-cycle op finishes in place; no stall and no state change.
                DoneE = 1'b1;
              end else begin
                holdE     = 1'b1;
                FlushM    = 1'b1;
                stateNext = RUN;
                cntNext   = MUL_LOAD;
                longNext  = 1'b0;
              end
            end
            CLS_DIV: begin
              // A zero divisor has a known result of 0, so the op takes one cycle.
              if (DivZeroE || (DIV_CYCLES == 1)) begin
                DoneE = 1'b1;
              end else begin
                holdE     = 1'b1;
                FlushM    = 1'b1;
                stateNext = RUN;
                cntNext   = DIV_LOAD;
                longNext  = 1'b0;
              end
            end
            CLS_LONG: begin
              holdE    = 1'b1;
              FlushM   = 1'b1;
              longNext = 1'b1;
              if (LONG_COMPUTE == 1) begin
                stateNext = LO;
                cntNext   = '0;
              end else begin
                stateNext = RUN;
                cntNext   = LONG_LOAD;
              end
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        BusyE = 1'b1;
        if (cnt == '0) begin
          if (longQ) begin
            // The compute phase of a long multiply ends stalled, and the
            // writebacks follow in LO and HI.
            holdE     = 1'b1;
            FlushM    = 1'b1;
            stateNext = LO;
          end else begin
            // Release cycle: the result leaves E and the younger stages move.
            DoneE     = 1'b1;
            stateNext = IDLE;
          end
        end else begin
          holdE   = 1'b1;
          FlushM  = 1'b1;
          cntNext = cnt - CNT_WIDTH'(1);
        end
      end

      LO: begin
        // The lo half goes to M while E holds the instruction for the hi half.
        BusyE     = 1'b1;
        holdE     = 1'b1;
        LoWriteE  = 1'b1;
        stateNext = HI;
      end

      HI: begin
        BusyE     = 1'b1;
        HiPhaseE  = 1'b1;
        DoneE     = 1'b1;
        stateNext = IDLE;
        longNext  = 1'b0;
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
        longNext  = 1'b0;
      end
    endcase

    // Abort kills the E instruction outright. If a lo half has already gone to
    // M it stays committed; the hi half is dropped. BusyE still reports that an
    // op occupied E during this cycle.
    if (AbortE) begin
      holdE     = 1'b0;
      LoWriteE  = 1'b0;
      HiPhaseE  = 1'b0;
      DoneE     = 1'b0;
      FlushM    = 1'b1;
      BusyE     = (state != IDLE);
      stateNext = IDLE;
      cntNext   = '0;
      longNext  = 1'b0;
    end
  end

  assign StallF      = holdE;
  assign StallD      = holdE;
  assign StallE      = holdE;
  assign DebugStateE = state;
  assign DebugCntE   = cnt;

endmodule
